lcd_number_formatter: RTL and testbench
=======================================

// Module: lcd_number_formatter
// PURPOSE
//   Upstream stage of LCD1602_controller. Converts a binary value (number1 path) to
//   fixed-width decimal ASCII with a sequential double-dabble. Converts a 4-bit
//   value (number2 path) to one hex ASCII character.
//   Pulses ready_o for one cycle when a fresh result is stable; ready_o drives the
//   controller's ready_i.
// PARAMETERS
//   VAL_WIDTH  16  binary input width; sets the number of shift iterations
//   DIGITS     5   decimal output digits; must satisfy 10^DIGITS > 2^VAL_WIDTH-1
// PORTS
//   clk            in   1            system clock, rising edge
//   reset          in   1            asynchronous, active-low reset
//   start_i        in   1            request conversion; sampled only in IDLE
//   value_i        in   VAL_WIDTH    binary value to format; captured with start_i
//   nibble_i       in   4            nibble to format as hex; captured with start_i
//   busy_o         out  1            conversion in progress (all states except IDLE)
//   ready_o        out  1            one-cycle pulse: digits_o/nibble_ascii_o are valid
//   digits_o       out  8*DIGITS     ASCII decimal; most significant digit in top byte
//   nibble_ascii_o out  8            ASCII hex character for nibble_i
// BEHAVIOUR
//   Reset (reset=0, async):
//   - state=IDLE, busy_o=0, ready_o=0
//   - digits_o = all 8'h30 ("00000"), nibble_ascii_o = 8'h30
//   - shift counter and BCD scratch cleared
//   FSM: IDLE -> SHIFT -> ENCODE -> DONE -> IDLE
//   - IDLE: at edge k with start_i=1, capture value_i and nibble_i, clear BCD,
//     set busy_o=1, go to SHIFT with count=0. start_i=0: stay in IDLE.
//   - SHIFT: one iteration per cycle:
//     - add 3 to every BCD digit >= 5
//     - shift {bcd, bin} left by 1
//     - after VAL_WIDTH iterations (edge k+VAL_WIDTH), go to ENCODE
//   - ENCODE, edge k+VAL_WIDTH+1:
//     - digits_o <= each BCD digit + 8'h30
//     - nibble_ascii_o <= 8'h30+n for n<=9, else 8'h41+(n-10) ('A'..'F')
//     - ready_o <= 1; go to DONE
//   - DONE: one cycle. Next edge: ready_o<=0, busy_o<=0, go to IDLE.
//   Timing:
//   - latency: start sample to ready_o high = VAL_WIDTH+1 edges (17 by default)
//   - busy_o high for VAL_WIDTH+2 cycles
//   - start_i held high: a new conversion every VAL_WIDTH+3 cycles (19)
//   Output rules:
//   - digits_o/nibble_ascii_o change only on the ENCODE edge
//   - between ENCODE edges they hold the previous result, including while busy
//   Boundary conditions:
//   - start_i while busy_o=1 (including during DONE) is ignored, not queued
//   - value_i/nibble_i changes after the capture edge do not affect the result
//   - value 0 gives all '0'; value 2^VAL_WIDTH-1 converts exactly, no overflow
//   - reset asserted mid-conversion aborts it: outputs return to reset values
//     and ready_o does not pulse
//   - a start_i after reset release is handled normally
// CONFIGURATION
//   LCD_LEADING_ZERO_BLANK_EN defined:
//   - in ENCODE, each leading zero digit (scanning from the MSD) becomes 8'h20 (space)
//   - the least significant digit is never blanked: 0 -> "    0", 8 -> "    8"
//   - the reset value of digits_o becomes "    0"
//   LCD_LEADING_ZERO_BLANK_EN undefined:
//   - zero-padded output: 8 -> "00008"
//   nibble_ascii_o is unaffected either way.
// TESTING
//   1 Hold reset=0 -> busy_o=0, ready_o=0, digits_o=40'h3030303030,
//     nibble_ascii_o=8'h30. Release; no start_i -> outputs unchanged.
//   2 value_i=16'h0008, nibble_i=4'hF, one-cycle start_i -> ready_o pulses exactly
//     once, 17 edges after the sample; digits_o=40'h3030303038 ("00008"),
//     nibble_ascii_o=8'h46. With LCD_LEADING_ZERO_BLANK_EN: 40'h2020202038.
//   3 value_i=16'hFFFF, nibble_i=4'h9 -> digits_o="65535" (40'h3635353335),
//     nibble_ascii_o=8'h39. value_i=0, nibble_i=4'hA -> "00000", 8'h41.
//   4 Start with 12345; 5 cycles later pulse start_i with value_i=999 -> exactly
//     one ready_o pulse; digits_o="12345". Hold start_i=1 continuously ->
//     ready_o pulses every 19 cycles.
//   5 Start with 54321; drive reset=0 during SHIFT iteration 8 -> outputs return
//     to reset values immediately; no ready_o pulse. After release, start with 42
//     -> "00042" after 17 edges.

Source files
------------

// File: rtl/lcd_number_formatter.sv
// lcd_number_formatter
//   Front end for the LCD1602 controller. A sequential double-dabble turns a
//   VAL_WIDTH-bit binary value into DIGITS ASCII decimal characters. A 4-bit
//   nibble is turned into one ASCII hex character alongside it. ready_o pulses
//   for one cycle when a fresh result has been loaded into the output registers.
//
//   Handshake: start_i is a request that is only looked at while idle
//   (busy_o=0). Requests made while busy are dropped, not queued. ready_o is a
//   single-cycle strobe with no back-pressure. The outputs hold their value
//   until the next ENCODE edge.
//
//   Optional feature: define LCD_LEADING_ZERO_BLANK_EN to replace leading zero
//   digits with spaces. The least significant digit is always shown.
//
//   dbg_state_o exposes the FSM state so it can be observed directly.
module lcd_number_formatter #(
    parameter int VAL_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [VAL_WIDTH-1:0]  value_i,
    input  logic [3:0]            nibble_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic [8*DIGITS-1:0]   digits_o,
    output logic [7:0]            nibble_ascii_o,
    output logic [1:0]            dbg_state_o
);

    localparam int CW = $clog2(VAL_WIDTH + 1);

`ifdef LCD_LEADING_ZERO_BLANK_EN
    localparam logic [8*DIGITS-1:0] DIGITS_RST = {{(DIGITS-1){8'h20}}, 8'h30};
`else
    localparam logic [8*DIGITS-1:0] DIGITS_RST = {DIGITS{8'h30}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [CW-1:0]         r_count;
    logic [VAL_WIDTH-1:0]  r_bin;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [3:0]            r_nibble;
    logic                  r_ready;
    logic [8*DIGITS-1:0]   r_digits;
    logic [7:0]            r_nib_ascii;
    logic [4*DIGITS-1:0]   w_bcd_adj;
    logic [8*DIGITS-1:0]   w_digits_enc;
    logic [7:0]            w_nib_enc;
    logic                  w_last_iter;

    assign busy_o         = (r_state != ST_IDLE);
    assign ready_o        = r_ready;
    assign digits_o       = r_digits;
    assign nibble_ascii_o = r_nib_ascii;
    assign dbg_state_o    = r_state;
    assign w_last_iter    = (r_count == CW'(VAL_WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> SHIFT -> ENCODE -> DONE -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start_i) w_next = ST_SHIFT;
            ST_SHIFT:  if (w_last_iter) w_next = ST_ENCODE;
            ST_ENCODE: w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every BCD digit of 5 or more before the shift
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // BCD to ASCII, with optional blanking of leading zeros (never the LSD)
    always_comb begin
`ifdef LCD_LEADING_ZERO_BLANK_EN
        logic v_lead;
        v_lead = 1'b1;
`endif
        w_digits_enc = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_digits_enc[8*i +: 8] = {4'h3, r_bcd[4*i +: 4]};
`ifdef LCD_LEADING_ZERO_BLANK_EN
            if (v_lead && (i != 0) && (r_bcd[4*i +: 4] == 4'd0)) begin
                w_digits_enc[8*i +: 8] = 8'h20;
            end else begin
                v_lead = 1'b0;
            end
`endif
        end
    end

    // Nibble to ASCII hex: '0'..'9' then 'A'..'F'
    always_comb begin
        w_nib_enc = 8'h30;
        if (r_nibble <= 4'd9) begin
            w_nib_enc = 8'h30 + {4'h0, r_nibble};
        end else begin
            w_nib_enc = 8'h41 + ({4'h0, r_nibble} - 8'd10);
        end
    end

    // Datapath: capture, shift iterations, output encode and ready strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_nibble    <= '0;
            r_ready     <= 1'b0;
            r_digits    <= DIGITS_RST;
            r_nib_ascii <= 8'h30;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ready <= 1'b0;
                    if (start_i) begin
                        r_bin    <= value_i;
                        r_nibble <= nibble_i;
                        r_bcd    <= '0;
                        r_count  <= '0;
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[4*DIGITS-2:0], r_bin, 1'b0};
                    r_count        <= r_count + 1'b1;
                end
                ST_ENCODE: begin
                    r_digits    <= w_digits_enc;
                    r_nib_ascii <= w_nib_enc;
                    r_ready     <= 1'b1;
                end
                ST_DONE: begin
                    r_ready <= 1'b0;
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_number_formatter.sv
// Directed bench for lcd_number_formatter (default VAL_WIDTH=16, DIGITS=5).
// Expected strings are hand-computed for both builds of the blanking option.
module tb_lcd_number_formatter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [15:0] value_i;
    logic [3:0]  nibble_i;
    logic        busy_o;
    logic        ready_o;
    logic [39:0] digits_o;
    logic [7:0]  nibble_ascii_o;
    logic [1:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;
    logic [39:0] prev_digits;

`ifdef LCD_LEADING_ZERO_BLANK_EN
    localparam logic [39:0] D_RST   = 40'h2020202030;
    localparam logic [39:0] D_8     = 40'h2020202038;
    localparam logic [39:0] D_0     = 40'h2020202030;
    localparam logic [39:0] D_7     = 40'h2020202037;
    localparam logic [39:0] D_42    = 40'h2020203432;
`else
    localparam logic [39:0] D_RST   = 40'h3030303030;
    localparam logic [39:0] D_8     = 40'h3030303038;
    localparam logic [39:0] D_0     = 40'h3030303030;
    localparam logic [39:0] D_7     = 40'h3030303037;
    localparam logic [39:0] D_42    = 40'h3030303432;
`endif
    localparam logic [39:0] D_65535 = 40'h3635353335;
    localparam logic [39:0] D_12345 = 40'h3132333435;

    lcd_number_formatter dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .value_i        (value_i),
        .nibble_i       (nibble_i),
        .busy_o         (busy_o),
        .ready_o        (ready_o),
        .digits_o       (digits_o),
        .nibble_ascii_o (nibble_ascii_o),
        .dbg_state_o    (dbg_state_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one conversion from a negedge with the DUT idle; optionally injects
    // a competing start pulse (value 999) inj_j cycles after the capture edge.
    task automatic run_conv(input string tag, input logic [15:0] v, input logic [3:0] n,
                            input int inj_j, input logic [39:0] exp_d, input logic [7:0] exp_n);
        int          pulses;
        int          first;
        logic [39:0] got_d;
        logic [7:0]  got_n;
        pulses = 0;
        first  = -1;
        got_d  = '0;
        got_n  = '0;
        start_i  = 1'b1;
        value_i  = v;
        nibble_i = n;
        @(negedge clk);
        start_i  = 1'b0;
        value_i  = 16'($urandom_range(0, 65535));
        nibble_i = 4'($urandom_range(0, 15));
        chk({tag, "_busy_start"}, busy_o, 1'b1);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == inj_j) begin
                start_i = 1'b1;
                value_i = 16'd999;
            end else begin
                start_i = 1'b0;
            end
            if (j == 16) chk({tag, "_hold_prev"}, digits_o, prev_digits);
            if (ready_o) begin
                pulses++;
                if (first < 0) begin
                    first = j;
                    got_d = digits_o;
                    got_n = nibble_ascii_o;
                end
            end
        end
        chk({tag, "_pulses"}, pulses, 1);
        chk({tag, "_latency"}, first, 17);
        chk({tag, "_digits"}, got_d, exp_d);
        chk({tag, "_nibble"}, got_n, exp_n);
        chk({tag, "_idle_after"}, busy_o, 1'b0);
        prev_digits = exp_d;
    endtask

    initial begin
        int          pulses;
        int          pos_q[$];
        reset    = 1'b0;
        start_i  = 1'b0;
        value_i  = '0;
        nibble_i = '0;
        prev_digits = D_RST;

        // 1: reset values, then idle with no start
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_digits", digits_o, D_RST);
        chk("rst_nibble", nibble_ascii_o, 8'h30);
        chk("rst_state", dbg_state_o, 2'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_ready", ready_o, 1'b0);
        chk("idle_digits", digits_o, D_RST);
        chk("idle_nibble", nibble_ascii_o, 8'h30);

        // 2 and 3: basic conversions and boundary values
        run_conv("v8", 16'h0008, 4'hF, -1, D_8, 8'h46);
        run_conv("vmax", 16'hFFFF, 4'h9, -1, D_65535, 8'h39);
        run_conv("v0", 16'h0000, 4'hA, -1, D_0, 8'h41);

        // 4: start while busy is ignored
        run_conv("v12345", 16'd12345, 4'hC, 5, D_12345, 8'h43);

        // 4: start held high -> one result every 19 cycles
        start_i  = 1'b1;
        value_i  = 16'd7;
        nibble_i = 4'h1;
        @(negedge clk);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (ready_o) pos_q.push_back(j);
        end
        start_i = 1'b0;
        chk("held_count", pos_q.size(), 3);
        if (pos_q.size() == 3) begin
            chk("held_pos0", pos_q[0], 17);
            chk("held_pos1", pos_q[1], 36);
            chk("held_pos2", pos_q[2], 55);
        end
        repeat (25) @(negedge clk);
        chk("held_digits", digits_o, D_7);
        chk("held_nibble", nibble_ascii_o, 8'h31);
        prev_digits = D_7;

        // 5: reset during SHIFT aborts the conversion
        start_i  = 1'b1;
        value_i  = 16'd54321;
        nibble_i = 4'hE;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_in_shift", dbg_state_o, 2'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_ready", ready_o, 1'b0);
        chk("abort_digits", digits_o, D_RST);
        chk("abort_nibble", nibble_ascii_o, 8'h30);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b1;
        pulses = 0;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            if (ready_o) pulses++;
        end
        chk("abort_no_ready", pulses, 0);
        prev_digits = D_RST;
        run_conv("v42", 16'd42, 4'h3, -1, D_42, 8'h33);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
